// File: rtl/pkg_74xx_serial.sv
// Shared definitions for the 74xx-style serial receive path.
package pkg_74xx_serial;

  // Width used when an instance does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Serial bit order on the wire; MSB arrives first.
  typedef enum logic [0:0] {
    MSB_FIRST = 1'b0
  } bit_order_e;

  // Bit counter width for a given register width (at least one bit).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mod_74x595_core.sv
// Shift register, storage register and frame bit counter of the 595 receiver.
module mod_74x595_core
  import pkg_74xx_serial::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit AUTO_LATCH = 1'b1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             ser_i,
  input  logic             shift_en_i,
  input  logic             rclk_en_i,
  input  logic             srclr_n_i,
  output logic [WIDTH-1:0] shift_o,
  output logic [WIDTH-1:0] storage_o,
  output logic             load_o
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] storage_q, storage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             load;

  assign shifted  = {shift_q[WIDTH-2:0], ser_i};
  assign complete = shift_en_i && (cnt_q == LAST_CNT);

  // Next-state: clear beats shift/latch; auto load beats the manual strobe.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    storage_d = storage_q;
    load      = 1'b0;
    if (!srclr_n_i) begin
      shift_d = '0;
      cnt_d   = '0;
      if (rclk_en_i) begin
        // The cleared register is what the storage stage sees.
        storage_d = '0;
        load      = 1'b1;
      end
    end else begin
      if (shift_en_i) begin
        shift_d = shifted;
        cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
      end
      if (AUTO_LATCH && complete) begin
        storage_d = shifted;
        load      = 1'b1;
      end else if (rclk_en_i) begin
        // Storage trails the shift stage by one: it takes the pre-shift value.
        storage_d = shift_q;
        load      = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      shift_q   <= '0;
      storage_q <= '0;
      cnt_q     <= '0;
    end else begin
      shift_q   <= shift_d;
      storage_q <= storage_d;
      cnt_q     <= cnt_d;
    end
  end

  assign shift_o   = shift_q;
  assign storage_o = storage_q;
  assign load_o    = load;

endmodule

// File: rtl/mod_74x595_rx.sv
// 74x595-style serial receiver: core plus handshake flags and tri-state output.
module mod_74x595_rx
  import pkg_74xx_serial::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit AUTO_LATCH = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SER,
  input  logic             SHIFT_EN,
  input  logic             RCLK_EN,
  input  logic             SRCLR_N,
  input  logic             OE_N,
  input  logic             ACK,
  output tri   [WIDTH-1:0] Q,
  output logic             QH_S,
  output logic             FRAME_VALID,
  output logic             OVERRUN
);

  logic [WIDTH-1:0] shift_w;
  logic [WIDTH-1:0] storage_w;
  logic             load_w;
  logic             fv_q, fv_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;

  mod_74x595_core #(
    .WIDTH      (WIDTH),
    .AUTO_LATCH (AUTO_LATCH)
  ) u_core (
    .clk        (CLK),
    .srst       (RST),
    .ser_i      (SER),
    .shift_en_i (SHIFT_EN),
    .rclk_en_i  (RCLK_EN),
    .srclr_n_i  (SRCLR_N),
    .shift_o    (shift_w),
    .storage_o  (storage_w),
    .load_o     (load_w)
  );

  // Handshake: an ACK in the same cycle as a load acknowledges the older frame.
  always_comb begin
    fv_d      = load_w;
    pending_d = load_w ? 1'b1 : (ACK ? 1'b0 : pending_q);
    overrun_d = ACK ? 1'b0 : (overrun_q | (load_w & pending_q));
  end

  // Flag registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fv_q      <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fv_q      <= fv_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Per-bit tri-state drivers for the parallel output.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_q
    assign Q[gi] = OE_N ? 1'bz : storage_w[gi];
  end

  assign QH_S        = shift_w[WIDTH-1];
  assign FRAME_VALID = fv_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_mod_74x595_rx.sv
// Self-checking bench: auto-latch and manual-latch instances against a reference model.
module tb_mod_74x595_rx;

  localparam int W = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SER = 1'b0;
  logic SHIFT_EN = 1'b0;
  logic RCLK_EN = 1'b0;
  logic SRCLR_N = 1'b1;
  logic OE_N = 1'b0;
  logic ACK = 1'b0;

  tri   [W-1:0] q_a, q_m;
  logic qhs_a, qhs_m, fv_a, fv_m, ovr_a, ovr_m;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state, index 0 = auto latch, 1 = manual latch.
  int unsigned m_sr[2];
  int unsigned m_cnt[2];
  int unsigned m_stor[2];
  bit m_pend[2];
  bit m_ovr[2];
  bit m_fv[2];

  always #5 CLK = ~CLK;

  mod_74x595_rx #(.WIDTH(W), .AUTO_LATCH(1'b1)) dut_auto (
    .CLK(CLK), .RST(RST), .SER(SER), .SHIFT_EN(SHIFT_EN), .RCLK_EN(RCLK_EN),
    .SRCLR_N(SRCLR_N), .OE_N(OE_N), .ACK(ACK), .Q(q_a), .QH_S(qhs_a),
    .FRAME_VALID(fv_a), .OVERRUN(ovr_a)
  );

  mod_74x595_rx #(.WIDTH(W), .AUTO_LATCH(1'b0)) dut_man (
    .CLK(CLK), .RST(RST), .SER(SER), .SHIFT_EN(SHIFT_EN), .RCLK_EN(RCLK_EN),
    .SRCLR_N(SRCLR_N), .OE_N(OE_N), .ACK(ACK), .Q(q_m), .QH_S(qhs_m),
    .FRAME_VALID(fv_m), .OVERRUN(ovr_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the receiver, stated as the behavioural rules of a 595 frame.
  function automatic void model_step(input int k);
    bit          load = 1'b0;
    int unsigned post;
    int unsigned nstor;
    if (RST) begin
      m_sr[k] = 0; m_cnt[k] = 0; m_stor[k] = 0;
      m_pend[k] = 0; m_ovr[k] = 0; m_fv[k] = 0;
      return;
    end
    nstor = m_stor[k];
    if (!SRCLR_N) begin
      if (RCLK_EN) begin load = 1'b1; nstor = 0; end
      m_sr[k] = 0;
      m_cnt[k] = 0;
    end else begin
      post = SHIFT_EN ? (((m_sr[k] << 1) | int'(SER)) & MASK) : m_sr[k];
      if (k == 0 && SHIFT_EN && m_cnt[k] == W - 1) begin
        load = 1'b1; nstor = post;
      end else if (RCLK_EN) begin
        load = 1'b1; nstor = m_sr[k];
      end
      if (SHIFT_EN) m_cnt[k] = (m_cnt[k] + 1) % W;
      m_sr[k] = post;
    end
    m_ovr[k]  = ACK ? 1'b0 : (m_ovr[k] | (load & m_pend[k]));
    m_pend[k] = load ? 1'b1 : (ACK ? 1'b0 : m_pend[k]);
    m_fv[k]   = load;
    m_stor[k] = nstor;
  endfunction

  task automatic check_all(input string tag);
    logic [W-1:0] eq;
    for (int k = 0; k < 2; k++) begin
      eq = OE_N ? {W{1'bz}} : W'(m_stor[k]);
      chk($sformatf("%s_q%0d", tag, k), (k == 0) ? q_a : q_m, eq);
      chk($sformatf("%s_qhs%0d", tag, k), (k == 0) ? qhs_a : qhs_m, 32'((m_sr[k] >> (W - 1)) & 1));
      chk($sformatf("%s_fv%0d", tag, k), (k == 0) ? fv_a : fv_m, 32'(m_fv[k]));
      chk($sformatf("%s_ovr%0d", tag, k), (k == 0) ? ovr_a : ovr_m, 32'(m_ovr[k]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
    check_all(tag);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit ack_last, input string tag);
    for (int i = W - 1; i >= 0; i--) begin
      SER = v[i];
      SHIFT_EN = 1'b1;
      ACK = ack_last && (i == 0);
      tick(tag);
    end
    SHIFT_EN = 1'b0;
    ACK = 1'b0;
  endtask

  initial begin
    logic [W-1:0] zz;
    logic [15:0]  stream;
    int           pulses;
    int           first_at;
    int           second_at;
    zz = {W{1'bz}};

    // 1: reset
    RST = 1'b1;
    tick("rst");
    tick("rst");
    RST = 1'b0;
    OE_N = 1'b0;
    tick("idle");
    chk("rst_q", q_a, 8'h00);
    chk("rst_qhs", qhs_a, 1'b0);
    chk("rst_fv", fv_a, 1'b0);
    chk("rst_ovr", ovr_a, 1'b0);

    // 2: one frame 0xA5
    send_byte(8'hA5, 1'b0, "a5");
    chk("a5_q", q_a, 8'hA5);
    chk("a5_fv_hi", fv_a, 1'b1);
    tick("a5_after");
    chk("a5_fv_lo", fv_a, 1'b0);

    // 3: partial frame discarded by clear; storage held through it
    for (int i = 0; i < 3; i++) begin
      SER = 1'b1; SHIFT_EN = 1'b1; tick("part");
    end
    SHIFT_EN = 1'b0;
    SRCLR_N = 1'b0;
    tick("clr");
    chk("clr_hold_q", q_a, 8'hA5);
    chk("clr_qhs", qhs_a, 1'b0);
    SRCLR_N = 1'b1;
    send_byte(8'h3C, 1'b0, "3c");
    chk("3c_q", q_a, 8'h3C);
    ACK = 1'b1; tick("ack"); ACK = 1'b0;

    // 4: overrun, then ACK on the completing edge
    send_byte(8'h11, 1'b0, "o11");
    send_byte(8'h22, 1'b0, "o22");
    chk("ovr_q", q_a, 8'h22);
    chk("ovr_set", ovr_a, 1'b1);
    ACK = 1'b1; tick("ovr_ack"); ACK = 1'b0;
    chk("ovr_clr", ovr_a, 1'b0);
    send_byte(8'h11, 1'b0, "p11");
    send_byte(8'h22, 1'b1, "p22");
    chk("ackedge_ovr", ovr_a, 1'b0);
    tick("p_idle");
    chk("ackedge_ovr2", ovr_a, 1'b0);

    // 5: manual latch instance
    send_byte(8'hF0, 1'b0, "f0");
    tick("hold");
    tick("hold");
    chk("man_hold_q", q_m, 8'h00);
    chk("man_hold_fv", fv_m, 1'b0);
    RCLK_EN = 1'b1; tick("rclk"); RCLK_EN = 1'b0;
    chk("man_q", q_m, 8'hF0);
    chk("man_fv", fv_m, 1'b1);
    OE_N = 1'b1;
    tick("oe");
    chk("oe_man_z", q_m, zz);
    chk("oe_auto_z", q_a, zz);
    OE_N = 1'b0;
    ACK = 1'b1; tick("ack2"); ACK = 1'b0;

    // 6: continuous stream of two frames
    stream = 16'h817E;
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 1; i <= 17; i++) begin
      SHIFT_EN = (i <= 16);
      SER = (i <= 16) ? stream[16 - i] : 1'b0;
      tick("strm");
      if (fv_a === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i; else second_at = i;
      end
      if (i == 8) chk("strm_q81", q_a, 8'h81);
      if (i == 16) chk("strm_q7e", q_a, 8'h7E);
    end
    SHIFT_EN = 1'b0;
    chk("strm_pulses", 32'(pulses), 32'd2);
    chk("strm_gap", 32'(second_at - first_at), 32'd8);

    // 7: randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      RST      = ($urandom_range(0, 49) == 0);
      SER      = 1'($urandom);
      SHIFT_EN = ($urandom_range(0, 3) != 0);
      RCLK_EN  = ($urandom_range(0, 7) == 0);
      SRCLR_N  = ($urandom_range(0, 15) != 0);
      ACK      = ($urandom_range(0, 5) == 0);
      OE_N     = ($urandom_range(0, 9) == 0);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
